// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Pipeline hazard controller for the RV32 core: load-use stalls for a
// configurable load latency, taken-branch flush and back-end freeze.
// Loads that have left EX are tracked in a short shift-register scoreboard
// (LOAD_LAT-1 entries); with LOAD_LAT=1 the block is the classic
// single-bubble load-use check.
//
// Optional build macro: HAZARD_PERF_CNT_EN
//   Adds perf_clr and three saturating performance counters
//   (load_stall_cnt, flush_cnt, mem_stall_cnt).
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_EX_Memread,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rd,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rs1,
  input  logic [REG_ADDR_W-1:0] IF_ID_Rs2,
  input  logic                  IF_ID_Rs1_used,
  input  logic                  IF_ID_Rs2_used,
  input  logic                  EX_branch_taken,
  input  logic                  mem_stall,
`ifdef HAZARD_PERF_CNT_EN
  input  logic                  perf_clr,
  output logic [PERF_CNT_W-1:0] load_stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt,
  output logic [PERF_CNT_W-1:0] mem_stall_cnt,
`endif
  output logic                  control_unit_select,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Flush
);

  // Number of scoreboard entries; kept at least 1 so declarations stay legal
  // even when the tracking generate branch is not built.
  localparam int TRK_N = (LOAD_LAT > 1) ? (LOAD_LAT - 1) : 1;

  // Reject out-of-range configurations at elaboration time.
  if (LOAD_LAT < 1 || LOAD_LAT > 8 || PERF_CNT_W < 1) begin : g_param_check
    $error("hazard_scoreboard_unit: LOAD_LAT must be 1..8 and PERF_CNT_W >= 1");
  end

  logic trk_hit_rs1;
  logic trk_hit_rs2;

  if (LOAD_LAT > 1) begin : g_trk
    logic [TRK_N:1]        trk_v;
    logic [REG_ADDR_W-1:0] trk_rd [1:TRK_N];

    // Shift loads leaving EX through the scoreboard; hold everything while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        trk_v <= '0;
        for (int k = 1; k <= TRK_N; k++) begin
          trk_rd[k] <= '0;
        end
      end else if (!mem_stall) begin
        trk_v[1]  <= ID_EX_Memread && (ID_EX_Rd != '0);
        trk_rd[1] <= ID_EX_Rd;
        for (int k = 2; k <= TRK_N; k++) begin
          trk_v[k]  <= trk_v[k-1];
          trk_rd[k] <= trk_rd[k-1];
        end
      end
    end

    // Compare both ID sources against every valid in-flight load.
    always_comb begin
      trk_hit_rs1 = 1'b0;
      trk_hit_rs2 = 1'b0;
      for (int k = 1; k <= TRK_N; k++) begin
        if (trk_v[k] && (trk_rd[k] == IF_ID_Rs1)) trk_hit_rs1 = 1'b1;
        if (trk_v[k] && (trk_rd[k] == IF_ID_Rs2)) trk_hit_rs2 = 1'b1;
      end
    end
  end else begin : g_no_trk
    assign trk_hit_rs1 = 1'b0;
    assign trk_hit_rs2 = 1'b0;
  end

  logic ex_hit_rs1;
  logic ex_hit_rs2;
  logic rs1_match;
  logic rs2_match;
  logic load_hazard;

  // x0 is never a real dependency, so a zero source can never match.
  assign ex_hit_rs1  = ID_EX_Memread && (ID_EX_Rd == IF_ID_Rs1);
  assign ex_hit_rs2  = ID_EX_Memread && (ID_EX_Rd == IF_ID_Rs2);
  assign rs1_match   = IF_ID_Rs1_used && (IF_ID_Rs1 != '0) && (ex_hit_rs1 || trk_hit_rs1);
  assign rs2_match   = IF_ID_Rs2_used && (IF_ID_Rs2 != '0) && (ex_hit_rs2 || trk_hit_rs2);
  assign load_hazard = rs1_match || rs2_match;

  logic case_freeze;
  logic case_flush;
  logic case_stall;

  // Priority resolution: freeze beats branch flush beats load-use stall.
  always_comb begin
    case_freeze = 1'b0;
    case_flush  = 1'b0;
    case_stall  = 1'b0;
    if (rst_n) begin
      if (mem_stall) begin
        case_freeze = 1'b1;
      end else if (EX_branch_taken) begin
        case_flush = 1'b1;
      end else if (load_hazard) begin
        case_stall = 1'b1;
      end
    end
  end

  // Drive pipeline controls from the winning case; run defaults otherwise.
  always_comb begin
    control_unit_select = 1'b0;
    PC_Write            = 1'b1;
    IF_ID_Write         = 1'b1;
    IF_ID_Flush         = 1'b0;
    ID_EX_Flush         = 1'b0;
    if (case_freeze) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
    end else if (case_flush) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (case_stall) begin
      control_unit_select = 1'b1;
      PC_Write            = 1'b0;
      IF_ID_Write         = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [PERF_CNT_W-1:0] CNT_ONE = PERF_CNT_W'(1);

  // Saturating event counters; a clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_stall_cnt <= '0;
      flush_cnt      <= '0;
      mem_stall_cnt  <= '0;
    end else if (perf_clr) begin
      load_stall_cnt <= '0;
      flush_cnt      <= '0;
      mem_stall_cnt  <= '0;
    end else begin
      if (case_stall && (load_stall_cnt != '1)) load_stall_cnt <= load_stall_cnt + CNT_ONE;
      if (case_flush && (flush_cnt != '1))      flush_cnt      <= flush_cnt + CNT_ONE;
      if (case_freeze && (mem_stall_cnt != '1)) mem_stall_cnt  <= mem_stall_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Next-generation pipeline hazard controller for the RV32 pipeline.
- Handles load-use stalls for a load latency set by a parameter. Loads that have left EX are tracked in a small shift-register scoreboard.
- Adds a taken-branch flush and a global back-end freeze (mem_stall).
- Drives the PC write enable, the IF/ID write enable, the bubble-select mux, and the IF/ID and ID/EX flush lines.

Parameters:
- REG_ADDR_W, 5, register-index width.
- LOAD_LAT, 1, cycles from a load leaving EX until its data is forwardable. 1 = classic 5-stage (no scoreboard entries). Legal range 1..8.
- PERF_CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_EX_Memread  in  1  instruction in EX is a load.
- ID_EX_Rd  in  REG_ADDR_W  destination of the instruction in EX.
- IF_ID_Rs1  in  REG_ADDR_W  source 1 of the instruction in ID.
- IF_ID_Rs2  in  REG_ADDR_W  source 2 of the instruction in ID.
- IF_ID_Rs1_used  in  1  ID instruction actually reads Rs1.
- IF_ID_Rs2_used  in  1  ID instruction actually reads Rs2.
- EX_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- mem_stall  in  1  data memory not ready; whole pipeline frozen.
- control_unit_select  out  1  1 = inject a bubble (zero controls) into ID/EX.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register write enable.
- IF_ID_Flush  out  1  clear IF/ID.
- ID_EX_Flush  out  1  clear ID/EX.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - all scoreboard valid bits clear;
  - outputs forced to run defaults: control_unit_select=0, PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0.
- Scoreboard: LOAD_LAT-1 entries trk[1..LOAD_LAT-1], each holding {v, rd}.
  - Rising clk with mem_stall=0: trk[1] <= {ID_EX_Memread && ID_EX_Rd!=0, ID_EX_Rd}; trk[k] <= trk[k-1]; the last entry falls off.
  - mem_stall=1: all entries hold.
  - LOAD_LAT=1: no storage; the block degenerates to the classic single-bubble check.
- Source match: a source matches when its _used=1, the register is nonzero, and it equals the destination of either a load in EX (ID_EX_Memread=1) or any valid trk[k].
- load_hazard = Rs1 match OR Rs2 match. Evaluated combinationally in the same cycle.
- Output priority, highest first:
  1. mem_stall=1: PC_Write=0, IF_ID_Write=0, control_unit_select=0, both flushes 0. The pipeline freezes and no bubble is inserted.
  2. EX_branch_taken=1: PC_Write=1 (redirect), IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1, control_unit_select=0. A concurrent load_hazard is discarded because the ID instruction is squashed.
  3. load_hazard=1: control_unit_select=1, PC_Write=0, IF_ID_Write=0, flushes 0.
  4. Otherwise: run defaults.
- Stall length: a dependent instruction directly behind a load stalls exactly LOAD_LAT cycles, plus any cycles with mem_stall=1. Inserted bubbles carry Memread=0, so they never create scoreboard entries.
- A load whose Rd is 0 never stalls and never occupies a valid entry.
- Latency: outputs respond combinationally to inputs and to the current scoreboard state; scoreboard update takes 1 cycle.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, the following ports are added:
  - perf_clr  in  1  synchronous clear.
  - load_stall_cnt  out  PERF_CNT_W  cycles with the load_hazard output active.
  - flush_cnt  out  PERF_CNT_W  cycles with the branch flush active.
  - mem_stall_cnt  out  PERF_CNT_W  cycles with mem_stall=1.
- Counter rules:
  - reset to 0;
  - increment by 1 per qualifying cycle, only for the winning priority case;
  - saturate at all ones;
  - perf_clr=1 zeroes them on the next edge and overrides an increment in the same cycle.
- When not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- LOAD_LAT=1, load x5 in EX, ID Rs1=5 used: control_unit_select=1, PC_Write=0 for exactly 1 cycle; next cycle run defaults.
- LOAD_LAT=3, load x7, dependent Rs2=7 next: stall for 3 consecutive cycles, released on cycle 4; trk[1] and trk[2] show v=1, rd=7 in turn.
- Load with Rd=0, ID Rs1=0 used; or load x9 with IF_ID_Rs1_used=0 and Rs1=9: no stall in either case.
- LOAD_LAT=3, load x4 in scoreboard, mem_stall=1 for 2 cycles mid-stall:
  - during the freeze: PC_Write=0, control_unit_select=0, scoreboard held;
  - after the freeze: remaining stall cycles complete (total 3 bubbles).
- EX_branch_taken=1 and load_hazard=1 in the same cycle: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, control_unit_select=0; with HAZARD_PERF_CNT_EN, flush_cnt+1 and load_stall_cnt unchanged.
- rst_n pulsed low mid-stall (LOAD_LAT=4): outputs return to defaults immediately and the scoreboard is empty after release; counters read 0.
